path_backtracker: RTL and testbench
===================================

Name: path_backtracker

Overview:
- Reads back the predecessor ("prev") array that the Dijkstra engine writes to block RAM after a search.
- Walks that array from the destination node to the source node and emits the shortest path as a node stream with a valid/accept handshake.
- Sits beside the Dijkstra engine on the same memory bus and acts as a read-only bus initiator. It is enabled only after the engine asserts ready.

Parameters:
- MADDR_WIDTH, `DEFAULT_MADDR_WIDTH: memory address width; one word is MADDR_WIDTH/8 address units.
- MDATA_WIDTH, `DEFAULT_MDATA_WIDTH: memory data width.
- MAX_NODES, `DEFAULT_MAX_NODES: largest supported graph.
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH: node index width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a backtrack when the block is idle, done or in error.
- source  in  INDEX_WIDTH  path start node.
- destination  in  INDEX_WIDTH  path end node; walking begins here.
- number_of_nodes  in  INDEX_WIDTH  graph size N.
- base_address  in  MADDR_WIDTH  graph base; prev[j] is at base_address + (N*N + j)*(MADDR_WIDTH/8).
- mem_read_enable  out(tri)  1  read request.
- mem_read_ready  in  1  read data valid.
- mem_addr  out(tri)  MADDR_WIDTH  read address.
- mem_read_data  in  MDATA_WIDTH  read data; bits [INDEX_WIDTH-1:0] carry the prev index.
- path_node  out  INDEX_WIDTH  current path node.
- path_valid  out  1  path_node is valid.
- path_accept  in  1  consumer takes path_node.
- path_length  out  INDEX_WIDTH  node count emitted, including source and destination.
- done  out  1  path completed.
- error  out  1  invalid input, unreachable destination or cycle detected.

Behaviour:
- Reset (asynchronous, reset==0):
  - State goes to IDLE.
  - path_valid, done and error are 0; path_node and path_length are 0.
  - mem_read_enable and mem_addr are high-Z.
- Bus sharing: mem_read_enable and mem_addr are driven only in READ; they are high-Z in every other state. No write port is provided.
- States: IDLE, EMIT, READ, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - Latch all inputs; current = destination; hops = 0; clear done and error.
  - If source >= N or destination >= N, go to ERROR next cycle.
  - Otherwise go to EMIT.
  - start is ignored in EMIT and READ.
- EMIT:
  - path_valid = 1 and path_node = current.
  - path_node is held stable while path_accept = 0.
  - On path_valid & path_accept, path_length increments.
  - If current == source, go to DONE.
  - Else if hops+1 == N, go to ERROR (cycle guard).
  - Else hops++ and go to READ.
- READ:
  - Drive mem_read_enable = 1 and mem_addr = prev address of current.
  - Both are held stable until mem_read_ready = 1.
  - In the cycle mem_read_ready = 1, sample mem_read_data[INDEX_WIDTH-1:0].
  - If the sample equals `NO_PREVIOUS_NODE or is >= N, go to ERROR.
  - Otherwise current = sample and go to EMIT. mem_read_enable is released the next cycle.
  - Arbitrary wait states are allowed; there is no timeout.
- DONE: done = 1 and path_valid = 0; path_length is held until the next start.
- ERROR: error = 1 and path_valid = 0; path_length holds the nodes emitted so far.
- Latency:
  - One cycle from start to the first path_valid.
  - Per hop: one EMIT cycle with accept, plus READ (1 + memory wait cycles).
- Address arithmetic: computed in MADDR_WIDTH bits, wrapping modulo 2^MADDR_WIDTH.
- Reset mid-READ: the bus releases to Z immediately and asynchronously. Nothing is emitted after reset deasserts until a new start.

Test Plan:
- N=4, prev=[NPN,0,1,1], src 0, dst 3, accept tied 1 -> path_node 3,1,0; path_length 3; done=1; exactly 2 memory reads, at base+(16+3)*4 and base+(16+1)*4 (MADDR_WIDTH=32).
- src == dst == 2, N=4 -> single node 2; path_length 1; done=1; mem_read_enable never driven.
- N=4, prev[3]=NPN, src 0, dst 3 -> emits 3, then error=1, path_length 1, done=0.
- Cycle: N=4, prev[3]=2, prev[2]=3, src 0, dst 3 -> emits 3,2,3,2; error asserts after the 4th accept; no 4th memory read.
- Backpressure and wait states: hold path_accept=0 for 5 cycles and delay mem_read_ready 3 cycles -> path_node and mem_addr stay stable throughout; output identical to the first scenario.
- Assert reset for 1 cycle while in READ -> bus is Z within the same cycle; path_valid, done and error are 0; a later start reruns correctly. Also: dst=5 with N=4 -> error on the cycle after start, no reads.

Source files
------------

// File: rtl/path_backtracker.sv
// Walks the Dijkstra predecessor array from destination back to source and
// streams the visited nodes out over a valid/accept handshake.
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 32
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 255
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 8
`endif
`ifndef NO_PREVIOUS_NODE
`define NO_PREVIOUS_NODE {INDEX_WIDTH{1'b1}}
`endif

module path_backtracker #(
    parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH,
    parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [INDEX_WIDTH-1:0] source,
    input  logic [INDEX_WIDTH-1:0] destination,
    input  logic [INDEX_WIDTH-1:0] number_of_nodes,
    input  logic [MADDR_WIDTH-1:0] base_address,
    output logic                   mem_read_enable,
    input  logic                   mem_read_ready,
    output logic [MADDR_WIDTH-1:0] mem_addr,
    input  logic [MDATA_WIDTH-1:0] mem_read_data,
    output logic [INDEX_WIDTH-1:0] path_node,
    output logic                   path_valid,
    input  logic                   path_accept,
    output logic [INDEX_WIDTH-1:0] path_length,
    output logic                   done,
    output logic                   error
);

    localparam logic [INDEX_WIDTH-1:0] NPN_L       = `NO_PREVIOUS_NODE;
    localparam logic [INDEX_WIDTH:0]   MAX_NODES_L = (INDEX_WIDTH+1)'(MAX_NODES);
    localparam logic [MADDR_WIDTH-1:0] BYTES_L     = MADDR_WIDTH'(MADDR_WIDTH / 8);

    typedef enum logic [2:0] {IDLE, EMIT, READ, DONE, ERROR} state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [INDEX_WIDTH-1:0] src_r;
    logic [INDEX_WIDTH-1:0] n_r;
    logic [INDEX_WIDTH-1:0] current_r;
    logic [INDEX_WIDTH-1:0] hops_r;
    logic [INDEX_WIDTH-1:0] path_length_r;
    logic [MADDR_WIDTH-1:0] base_r;
    logic [MADDR_WIDTH-1:0] addr_r;

    logic                   inputs_bad_s;
    logic                   hop_last_s;
    logic [INDEX_WIDTH-1:0] sample_s;
    logic                   sample_bad_s;
    logic [MADDR_WIDTH-1:0] n_ext_s;
    logic [MADDR_WIDTH-1:0] cur_ext_s;
    logic [MADDR_WIDTH-1:0] prev_addr_s;
    logic                   unused_data_bits_s;

    assign inputs_bad_s = (source >= number_of_nodes) || (destination >= number_of_nodes)
                        || ({1'b0, number_of_nodes} > MAX_NODES_L);
    // Cycle guard: N nodes emitted without reaching source means a loop.
    assign hop_last_s   = ((hops_r + INDEX_WIDTH'(1)) == n_r);
    assign sample_s     = mem_read_data[INDEX_WIDTH-1:0];
    assign sample_bad_s = (sample_s == NPN_L) || (sample_s >= n_r);
    assign unused_data_bits_s = ^mem_read_data;

    // prev[j] sits right after the N*N adjacency matrix; arithmetic wraps in address width.
    assign n_ext_s     = MADDR_WIDTH'(n_r);
    assign cur_ext_s   = MADDR_WIDTH'(current_r);
    assign prev_addr_s = base_r + ((n_ext_s * n_ext_s) + cur_ext_s) * BYTES_L;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_next_s = inputs_bad_s ? ERROR : EMIT;
                end else begin
                    state_next_s = state_r;
                end
            end
            EMIT: begin
                if (!path_accept) begin
                    state_next_s = EMIT;
                end else if (current_r == src_r) begin
                    state_next_s = DONE;
                end else if (hop_last_s) begin
                    state_next_s = ERROR;
                end else begin
                    state_next_s = READ;
                end
            end
            READ: begin
                if (mem_read_ready) begin
                    state_next_s = sample_bad_s ? ERROR : EMIT;
                end else begin
                    state_next_s = READ;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Walk registers: latched request, current node, hop count, read address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            src_r         <= {INDEX_WIDTH{1'b0}};
            n_r           <= {INDEX_WIDTH{1'b0}};
            current_r     <= {INDEX_WIDTH{1'b0}};
            hops_r        <= {INDEX_WIDTH{1'b0}};
            path_length_r <= {INDEX_WIDTH{1'b0}};
            base_r        <= {MADDR_WIDTH{1'b0}};
            addr_r        <= {MADDR_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        src_r         <= source;
                        n_r           <= number_of_nodes;
                        base_r        <= base_address;
                        current_r     <= destination;
                        hops_r        <= {INDEX_WIDTH{1'b0}};
                        path_length_r <= {INDEX_WIDTH{1'b0}};
                    end
                end
                EMIT: begin
                    if (path_accept) begin
                        path_length_r <= path_length_r + INDEX_WIDTH'(1);
                        if (state_next_s == READ) begin
                            hops_r <= hops_r + INDEX_WIDTH'(1);
                            addr_r <= prev_addr_s;
                        end
                    end
                end
                READ: begin
                    if (mem_read_ready && !sample_bad_s) begin
                        current_r <= sample_s;
                    end
                end
                default: current_r <= current_r;
            endcase
        end
    end

    // Bus is shared with the engine, so it is only driven while reading.
    assign mem_read_enable = (state_r == READ) ? 1'b1 : 1'bz;
    assign mem_addr        = (state_r == READ) ? addr_r : {MADDR_WIDTH{1'bz}};

    assign path_valid  = (state_r == EMIT);
    assign done        = (state_r == DONE);
    assign error       = (state_r == ERROR);
    assign path_node   = current_r;
    assign path_length = path_length_r;

endmodule

// File: tb/tb_path_backtracker.sv
// Directed bench for path_backtracker: small predecessor memory with
// programmable wait states, node-stream capture and immediate-assert checks.
module tb_path_backtracker;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  source;
    logic [7:0]  destination;
    logic [7:0]  number_of_nodes;
    logic [31:0] base_address;
    wire         mem_read_enable;
    logic        mem_read_ready;
    wire  [31:0] mem_addr;
    logic [31:0] mem_read_data;
    logic [7:0]  path_node;
    logic        path_valid;
    logic        path_accept;
    logic [7:0]  path_length;
    logic        done;
    logic        error;

    int          n_cmp = 0;
    int          n_err = 0;

    logic [7:0]  prev_mem [0:3];
    int          mem_delay = 0;
    int          wait_cnt = 0;
    logic [31:0] first_addr;
    int          addr_unstable = 0;
    int          en_cycles = 0;
    int          rd_n = 0;
    logic [31:0] rd_addr [0:7];
    int          em_n = 0;
    logic [7:0]  em [0:7];

    path_backtracker dut (
        .clock(clock), .reset(reset), .start(start),
        .source(source), .destination(destination), .number_of_nodes(number_of_nodes),
        .base_address(base_address),
        .mem_read_enable(mem_read_enable), .mem_read_ready(mem_read_ready),
        .mem_addr(mem_addr), .mem_read_data(mem_read_data),
        .path_node(path_node), .path_valid(path_valid), .path_accept(path_accept),
        .path_length(path_length), .done(done), .error(error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Negedge monitor and memory responder; upper data bits carry junk on purpose.
    initial begin
        mem_read_ready = 1'b0;
        mem_read_data  = 32'h0;
        forever begin
            @(negedge clock);
            if (path_valid === 1'b1 && path_accept === 1'b1) begin
                if (em_n < 8) em[em_n] = path_node;
                em_n++;
            end
            if (mem_read_ready === 1'b1) begin
                mem_read_ready = 1'b0;
                wait_cnt = 0;
            end else if (mem_read_enable === 1'b1) begin
                en_cycles++;
                if (wait_cnt == 0) first_addr = mem_addr;
                else if (mem_addr !== first_addr) addr_unstable++;
                if (wait_cnt >= mem_delay) begin
                    int j;
                    j = int'((mem_addr - base_address) / 32'd4) - 16;
                    mem_read_data = (j >= 0 && j < 4) ? {24'h5A5A5A, prev_mem[j]} : 32'hEEEE_EEEE;
                    mem_read_ready = 1'b1;
                    if (rd_n < 8) rd_addr[rd_n] = mem_addr;
                    rd_n++;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        em_n = 0; rd_n = 0; en_cycles = 0; addr_unstable = 0;
    endtask

    task automatic run(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
        @(posedge clock); #1;
        source = s; destination = d; number_of_nodes = n; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int k;
        k = 0;
        while (!(done === 1'b1 || error === 1'b1) && k < 200) begin
            @(posedge clock); #1;
            k++;
        end
        n_cmp++;
        assert (k < 200) else begin
            n_err++;
            $error("FAIL %s_timeout: observed no done/error after %0d cycles, expected done or error", tag, k);
        end
    endtask

    task automatic check_path(input string tag, input int len, input logic [7:0] e0,
                              input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_n [0:3];
        exp_n[0] = e0; exp_n[1] = e1; exp_n[2] = e2; exp_n[3] = e3;
        check({tag, "_count"}, em_n, len);
        for (int i = 0; i < len && i < em_n; i++) begin
            check($sformatf("%s_node%0d", tag, i), {24'h0, em[i]}, {24'h0, exp_n[i]});
        end
    endtask

    task automatic check_s1_result(input string tag);
        check_path(tag, 3, 8'd3, 8'd1, 8'd0, 8'd0);
        check({tag, "_len"},   {24'h0, path_length}, 32'd3);
        check({tag, "_done"},  {31'h0, done}, 32'd1);
        check({tag, "_error"}, {31'h0, error}, 32'd0);
        check({tag, "_reads"}, rd_n, 32'd2);
        check({tag, "_addr0"}, rd_addr[0], 32'h0000_104C);
        check({tag, "_addr1"}, rd_addr[1], 32'h0000_1044);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; path_accept = 1'b1;
        source = 8'd0; destination = 8'd0; number_of_nodes = 8'd4;
        base_address = 32'h0000_1000;
        prev_mem[0] = 8'hFF; prev_mem[1] = 8'd0; prev_mem[2] = 8'd1; prev_mem[3] = 8'd1;

        // Reset state.
        #12;
        check("rst_valid", {31'h0, path_valid}, 32'd0);
        check("rst_done",  {31'h0, done}, 32'd0);
        check("rst_error", {31'h0, error}, 32'd0);
        check("rst_node",  {24'h0, path_node}, 32'd0);
        check("rst_len",   {24'h0, path_length}, 32'd0);
        check("rst_bus_released", {31'h0, (mem_read_enable !== 1'b1)}, 32'd1);
        @(posedge clock); #1;
        reset = 1'b1;

        // Basic walk 3 -> 1 -> 0.
        clear_log();
        run(8'd0, 8'd3, 8'd4);
        check("s1_first_valid", {31'h0, path_valid}, 32'd1);
        check("s1_first_node",  {24'h0, path_node}, 32'd3);
        wait_end("s1");
        check_s1_result("s1");

        // Source equals destination: single node, no bus traffic.
        clear_log();
        run(8'd2, 8'd2, 8'd4);
        wait_end("s2");
        check_path("s2", 1, 8'd2, 8'd0, 8'd0, 8'd0);
        check("s2_len",  {24'h0, path_length}, 32'd1);
        check("s2_done", {31'h0, done}, 32'd1);
        check("s2_bus_cycles", en_cycles, 32'd0);

        // Unreachable destination.
        prev_mem[3] = 8'hFF;
        clear_log();
        run(8'd0, 8'd3, 8'd4);
        wait_end("s3");
        check_path("s3", 1, 8'd3, 8'd0, 8'd0, 8'd0);
        check("s3_error", {31'h0, error}, 32'd1);
        check("s3_done",  {31'h0, done}, 32'd0);
        check("s3_len",   {24'h0, path_length}, 32'd1);

        // Cycle 3 <-> 2 trips the hop guard after four nodes.
        prev_mem[3] = 8'd2; prev_mem[2] = 8'd3;
        clear_log();
        run(8'd0, 8'd3, 8'd4);
        wait_end("s4");
        check_path("s4", 4, 8'd3, 8'd2, 8'd3, 8'd2);
        check("s4_error", {31'h0, error}, 32'd1);
        check("s4_len",   {24'h0, path_length}, 32'd4);
        check("s4_reads", rd_n, 32'd3);

        // Backpressure and memory wait states.
        prev_mem[2] = 8'd1; prev_mem[3] = 8'd1;
        mem_delay = 3;
        path_accept = 1'b0;
        clear_log();
        run(8'd0, 8'd3, 8'd4);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("s5_hold_valid%0d", i), {31'h0, path_valid}, 32'd1);
            check($sformatf("s5_hold_node%0d", i), {24'h0, path_node}, 32'd3);
            @(posedge clock); #1;
        end
        path_accept = 1'b1;
        wait_end("s5");
        check_s1_result("s5");
        check("s5_addr_stable", addr_unstable, 32'd0);
        check("s5_bus_cycles", en_cycles, 32'd8);

        // Reset while READ is waiting on memory.
        mem_delay = 20;
        clear_log();
        run(8'd0, 8'd3, 8'd4);
        begin
            int k;
            k = 0;
            while (mem_read_enable !== 1'b1 && k < 20) begin
                @(posedge clock); #1;
                k++;
            end
            check("s6_reached_read", {31'h0, mem_read_enable === 1'b1}, 32'd1);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("s6_bus_released", {31'h0, (mem_read_enable !== 1'b1)}, 32'd1);
        check("s6_valid", {31'h0, path_valid}, 32'd0);
        check("s6_done",  {31'h0, done}, 32'd0);
        check("s6_error", {31'h0, error}, 32'd0);
        check("s6_len",   {24'h0, path_length}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("s6_quiet_valid", {31'h0, path_valid}, 32'd0);
        check("s6_quiet_emits", em_n, 32'd1);
        mem_delay = 0;
        clear_log();
        run(8'd0, 8'd3, 8'd4);
        wait_end("s6r");
        check_s1_result("s6r");

        // Destination out of range.
        clear_log();
        run(8'd0, 8'd5, 8'd4);
        check("s7_error", {31'h0, error}, 32'd1);
        check("s7_valid", {31'h0, path_valid}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        check("s7_bus_cycles", en_cycles, 32'd0);
        check("s7_emits", em_n, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
